// File: rtl/regfile_mp.sv
// Multi-port integer register file: two prioritised write ports, NUM_RD combinational
// read ports with optional same-cycle bypass, and a sequencer that zeroes every entry.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              we0,
  input  logic [$clog2(NREGS)-1:0]          waddr0,
  input  logic [XLEN-1:0]                   wdata0,
  input  logic                              we1,
  input  logic [$clog2(NREGS)-1:0]          waddr1,
  input  logic [XLEN-1:0]                   wdata1,
  input  logic [NUM_RD*$clog2(NREGS)-1:0]   raddr,
  output logic [NUM_RD*XLEN-1:0]            rdata,
  input  logic                              init_req,
  output logic                              busy
);

  localparam int AW = $clog2(NREGS);
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic [XLEN-1:0] mem_q [NREGS];
  logic            ready;
  logic            wen0, wen1;

  assign ready = (state_q == READY);
  assign busy  = ~ready;

  // Writes only land in READY; entry 0 swallows writes when hardwired to zero.
  assign wen0 = ready && we0 && !((ZERO_REG != 0) && (waddr0 == '0));
  assign wen1 = ready && we1 && !((ZERO_REG != 0) && (waddr1 == '0));

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      CLEAR: begin
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == AW'(NREGS - 1)) state_d = READY;
      end
      default: begin
        if (init_req) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem_q[clr_idx_q] <= '0;
    end else begin
      if (wen0) mem_q[waddr0] <= wdata0;
      if (wen1) mem_q[waddr1] <= wdata1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;

    assign ra = raddr[k*AW +: AW];

    always_comb begin
      rd = mem_q[ra];
      if ((BYPASS != 0) && wen1 && (ra == waddr1)) begin
        rd = wdata1;
      end else if ((BYPASS != 0) && wen0 && (ra == waddr0)) begin
        rd = wdata0;
      end
      if (!ready || ((ZERO_REG != 0) && (ra == '0))) rd = '0;
    end

    assign rdata[k*XLEN +: XLEN] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default config (a), no-bypass/no-zero-reg config (b),
// and a 4-port 16x64 config (c), all on one clock and reset.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we0, we1, init_req;
  logic [4:0]  waddr0, waddr1;
  logic [31:0] wdata0, wdata1;
  logic [9:0]  raddr;
  logic [63:0] rdata_a, rdata_b;
  logic        busy_a, busy_b;

  logic        wec0, wec1, init_c;
  logic [3:0]  waddrc0, waddrc1;
  logic [63:0] wdatac0, wdatac1;
  logic [15:0] raddr_c;
  logic [255:0] rdata_c;
  logic        busy_c;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  regfile_mp dut_a (
    .clk(clk), .rst_n(rst_n), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .raddr(raddr), .rdata(rdata_a),
    .init_req(init_req), .busy(busy_a)
  );

  regfile_mp #(.BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .raddr(raddr), .rdata(rdata_b),
    .init_req(init_req), .busy(busy_b)
  );

  regfile_mp #(.XLEN(64), .NREGS(16), .NUM_RD(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .we0(wec0), .waddr0(waddrc0), .wdata0(wdatac0),
    .we1(wec1), .waddr1(waddrc1), .wdata1(wdatac1), .raddr(raddr_c), .rdata(rdata_c),
    .init_req(init_c), .busy(busy_c)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    we0 = 1'b0; we1 = 1'b0; init_req = 1'b0;
    wec0 = 1'b0; wec1 = 1'b0; init_c = 1'b0;
  endtask

  task automatic test_reset;
    int n, cc;
    idle();
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; raddr = '0;
    waddrc0 = '0; waddrc1 = '0; wdatac0 = '0; wdatac1 = '0; raddr_c = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    nvec++; if ({busy_a, busy_b, busy_c} !== 3'b111) begin
      nmis++; $display("FAIL reset_busy: got %b want 111", {busy_a, busy_b, busy_c});
    end
    tick(); tick();
    nvec++; if (busy_a !== 1'b1 || rdata_a !== 64'd0) begin
      nmis++; $display("FAIL reset_hold: busy %b rdata %h want 1 / 0", busy_a, rdata_a);
    end
    rst_n = 1'b1;
    n = 0; cc = 0;
    while (busy_a === 1'b1 && n < 100) begin
      raddr = {5'(31 - n), 5'(n)};
      #1;
      nvec++; if (rdata_a !== 64'd0 || rdata_b !== 64'd0) begin
        nmis++; $display("FAIL clear_rd n=%0d: a %h b %h want 0", n, rdata_a, rdata_b);
      end
      tick();
      n++;
      if (busy_c === 1'b0 && cc == 0) cc = n;
    end
    nvec++; if (n != 32) begin nmis++; $display("FAIL clear_len_a: got %0d want 32", n); end
    nvec++; if (cc != 16) begin nmis++; $display("FAIL clear_len_c: got %0d want 16", cc); end
    nvec++; if (busy_b !== 1'b0) begin nmis++; $display("FAIL busy_b: got %b want 0", busy_b); end
    for (int i = 0; i < 32; i++) begin
      raddr = {5'(31 - i), 5'(i)};
      #1;
      nvec++; if (rdata_a !== 64'd0 || rdata_b !== 64'd0) begin
        nmis++; $display("FAIL ready_zero i=%0d: a %h b %h want 0", i, rdata_a, rdata_b);
      end
    end
  endtask

  task automatic test_bypass;
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; raddr = {5'd6, 5'd5};
    #1;
    nvec++; if (rdata_a !== {32'h0, 32'hDEADBEEF}) begin
      nmis++; $display("FAIL byp_a: got %h want 00000000deadbeef", rdata_a);
    end
    nvec++; if (rdata_b !== 64'd0) begin
      nmis++; $display("FAIL nobyp_b: got %h want 0", rdata_b);
    end
    tick(); idle(); #1;
    nvec++; if (rdata_a[31:0] !== 32'hDEADBEEF || rdata_b[31:0] !== 32'hDEADBEEF) begin
      nmis++; $display("FAIL byp_next: a %h b %h want deadbeef", rdata_a[31:0], rdata_b[31:0]);
    end
  endtask

  task automatic test_priority;
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22; raddr = {5'd7, 5'd7};
    #1;
    nvec++; if (rdata_a !== {32'h22, 32'h22}) begin
      nmis++; $display("FAIL prio_byp: got %h want 0000002200000022", rdata_a);
    end
    nvec++; if (rdata_b !== 64'd0) begin
      nmis++; $display("FAIL prio_nobyp: got %h want 0", rdata_b);
    end
    tick(); idle(); #1;
    nvec++; if (rdata_a !== {32'h22, 32'h22} || rdata_b !== {32'h22, 32'h22}) begin
      nmis++; $display("FAIL prio_store: a %h b %h want 22/22", rdata_a, rdata_b);
    end
    we0 = 1'b1; waddr0 = 5'd9;  wdata0 = 32'h99;
    we1 = 1'b1; waddr1 = 5'd10; wdata1 = 32'hAA; raddr = {5'd10, 5'd9};
    #1;
    nvec++; if (rdata_a !== {32'hAA, 32'h99}) begin
      nmis++; $display("FAIL dual_byp: got %h want 000000aa00000099", rdata_a);
    end
    tick(); idle(); #1;
    nvec++; if (rdata_a !== {32'hAA, 32'h99} || rdata_b !== {32'hAA, 32'h99}) begin
      nmis++; $display("FAIL dual_store: a %h b %h want aa/99", rdata_a, rdata_b);
    end
  endtask

  task automatic test_zero_reg;
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h12345678;
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFFFFFF; raddr = {5'd0, 5'd0};
    #1;
    nvec++; if (rdata_a !== 64'd0 || rdata_b !== 64'd0) begin
      nmis++; $display("FAIL zero_same: a %h b %h want 0", rdata_a, rdata_b);
    end
    tick(); idle(); #1;
    nvec++; if (rdata_a !== 64'd0) begin
      nmis++; $display("FAIL zero_a: got %h want 0", rdata_a);
    end
    nvec++; if (rdata_b !== {32'hFFFFFFFF, 32'hFFFFFFFF}) begin
      nmis++; $display("FAIL ordinary_b: got %h want ffffffffffffffff", rdata_b);
    end
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h12345678;
    #1;
    nvec++; if (rdata_a !== 64'd0 || rdata_b[31:0] !== 32'hFFFFFFFF) begin
      nmis++; $display("FAIL zero_byp: a %h b %h want 0 / ffffffff", rdata_a, rdata_b[31:0]);
    end
    tick(); idle(); #1;
    nvec++; if (rdata_b !== {32'h12345678, 32'h12345678}) begin
      nmis++; $display("FAIL ordinary_b2: got %h want 12345678 x2", rdata_b);
    end
  endtask

  task automatic test_init_clear;
    int n;
    for (int i = 1; i < 32; i += 2) begin
      we0 = 1'b1; waddr0 = 5'(i); wdata0 = 32'(i);
      we1 = (i + 1 < 32); waddr1 = 5'(i + 1); wdata1 = 32'(i + 1);
      tick();
    end
    idle();
    for (int i = 1; i < 32; i++) begin
      raddr = {5'(i), 5'(i)};
      #1;
      nvec++; if (rdata_a[31:0] !== 32'(i) || rdata_b[63:32] !== 32'(i)) begin
        nmis++; $display("FAIL fill i=%0d: a %h b %h", i, rdata_a[31:0], rdata_b[63:32]);
      end
    end
    init_req = 1'b1; we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h333;
    tick(); idle();
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin
      we0 = 1'b1; waddr0 = 5'(n % 31 + 1);  wdata0 = 32'hBAD00000 + 32'(n);
      we1 = 1'b1; waddr1 = 5'(31 - n % 31); wdata1 = 32'hC0DE0000 + 32'(n);
      init_req = (n == 20);
      raddr = {5'(n), 5'(31 - n)};
      #1;
      nvec++; if (rdata_a !== 64'd0 || rdata_b !== 64'd0) begin
        nmis++; $display("FAIL init_rd n=%0d: a %h b %h want 0", n, rdata_a, rdata_b);
      end
      tick();
      n++;
    end
    idle();
    nvec++; if (n != 32) begin nmis++; $display("FAIL init_len: got %0d want 32", n); end
    nvec++; if (busy_b !== 1'b0) begin nmis++; $display("FAIL init_busy_b: got %b want 0", busy_b); end
    for (int i = 0; i < 32; i++) begin
      raddr = {5'(i), 5'(i)};
      #1;
      nvec++; if (rdata_a !== 64'd0 || rdata_b !== 64'd0) begin
        nmis++; $display("FAIL init_zero i=%0d: a %h b %h want 0", i, rdata_a, rdata_b);
      end
    end
  endtask

  task automatic test_reset_mid_clear;
    int n, cc;
    we0 = 1'b1; waddr0 = 5'd31; wdata0 = 32'h31;
    tick(); idle();
    init_req = 1'b1;
    tick(); idle();
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    nvec++; if ({busy_a, busy_b, busy_c} !== 3'b111) begin
      nmis++; $display("FAIL mid_busy: got %b want 111", {busy_a, busy_b, busy_c});
    end
    tick(); tick();
    rst_n = 1'b1;
    n = 0; cc = 0;
    while (busy_a === 1'b1 && n < 100) begin
      tick();
      n++;
      if (busy_c === 1'b0 && cc == 0) cc = n;
    end
    nvec++; if (n != 32) begin nmis++; $display("FAIL mid_len_a: got %0d want 32", n); end
    nvec++; if (cc != 16) begin nmis++; $display("FAIL mid_len_c: got %0d want 16", cc); end
    raddr = {5'd31, 5'd31};
    #1;
    nvec++; if (rdata_a !== 64'd0 || rdata_b !== 64'd0) begin
      nmis++; $display("FAIL mid_zero: a %h b %h want 0", rdata_a, rdata_b);
    end
  endtask

  task automatic test_wide;
    logic [63:0] exp [4];
    nvec++; if (busy_c !== 1'b0) begin nmis++; $display("FAIL wide_busy: got %b want 0", busy_c); end
    wec0 = 1'b1; waddrc0 = 4'd3; wdatac0 = 64'h0123456789ABCDEF;
    wec1 = 1'b1; waddrc1 = 4'd9; wdatac1 = 64'hFEDCBA9876543210;
    raddr_c = {4'd0, 4'd9, 4'd3, 4'd15};
    exp = '{64'h0, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0};
    #1;
    for (int k = 0; k < 4; k++) begin
      nvec++; if (rdata_c[k*64 +: 64] !== exp[k]) begin
        nmis++; $display("FAIL wide_c1 port%0d: got %h want %h", k, rdata_c[k*64 +: 64], exp[k]);
      end
    end
    tick(); idle();
    wec0 = 1'b1; waddrc0 = 4'd15; wdatac0 = 64'h8000000000000001;
    raddr_c = {4'd3, 4'd3, 4'd9, 4'd15};
    exp = '{64'h8000000000000001, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF};
    #1;
    for (int k = 0; k < 4; k++) begin
      nvec++; if (rdata_c[k*64 +: 64] !== exp[k]) begin
        nmis++; $display("FAIL wide_c2 port%0d: got %h want %h", k, rdata_c[k*64 +: 64], exp[k]);
      end
    end
    tick(); idle();
    wec1 = 1'b1; waddrc1 = 4'd0; wdatac1 = 64'hFFFFFFFFFFFFFFFF;
    raddr_c = {4'd0, 4'd9, 4'd9, 4'd15};
    exp = '{64'h8000000000000001, 64'hFEDCBA9876543210, 64'hFEDCBA9876543210, 64'h0};
    #1;
    for (int k = 0; k < 4; k++) begin
      nvec++; if (rdata_c[k*64 +: 64] !== exp[k]) begin
        nmis++; $display("FAIL wide_c3 port%0d: got %h want %h", k, rdata_c[k*64 +: 64], exp[k]);
      end
    end
    tick(); idle(); #1;
    nvec++; if (rdata_c[192 +: 64] !== 64'h0) begin
      nmis++; $display("FAIL wide_zero: got %h want 0", rdata_c[192 +: 64]);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_priority();
    test_zero_reg();
    test_init_clear();
    test_reset_mid_clear();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
